// File: rtl/switch_allocator_pkg.sv
// Shared constants, direction names, FSM encodings and helpers for the switch allocator.
package switch_allocator_pkg;

  localparam int NUM_PORTS = 4;
  localparam int FLIT_W    = 6;
  localparam int ROUTE_W   = 2;

  localparam logic [ROUTE_W-1:0] DIR_N = 2'd0;
  localparam logic [ROUTE_W-1:0] DIR_E = 2'd1;
  localparam logic [ROUTE_W-1:0] DIR_S = 2'd2;
  localparam logic [ROUTE_W-1:0] DIR_W = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // The route field sits in the top bits of every modified header flit.
  function automatic logic [ROUTE_W-1:0] flit_route(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: ROUTE_W];
  endfunction

endpackage

// File: rtl/switch_allocator_arb.sv
// Combinational 4-way round-robin arbiter; the search starts at ptr and wraps.
module rr_arbiter_4
  import switch_allocator_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ROUTE_W-1:0]   ptr,
  output logic                 gnt_valid,
  output logic [ROUTE_W-1:0]   gnt_idx
);

  logic [ROUTE_W-1:0] cand;

  // Walk the requesters from ptr upward and take the first one that asks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = ptr + ROUTE_W'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output packet arbiter and crossbar: one IDLE/BUSY FSM per output, grants held head to tail.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
  input  logic [NUM_PORTS-1:0]          in_tail,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
  output logic [NUM_PORTS-1:0]          out_tail,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS*ROUTE_W-1:0]  out_owner,
  output logic [NUM_PORTS-1:0]          out_busy
);

  logic [0:0]           state_q [NUM_PORTS];
  logic [0:0]           state_d [NUM_PORTS];
  logic [ROUTE_W-1:0]   owner_q [NUM_PORTS];
  logic [ROUTE_W-1:0]   owner_d [NUM_PORTS];
  logic [ROUTE_W-1:0]   ptr_q   [NUM_PORTS];
  logic [ROUTE_W-1:0]   ptr_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0] locked;
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [ROUTE_W-1:0]   gnt_idx [NUM_PORTS];

  // An input is locked while it owns any busy output; its later flits must not start a new grant.
  always_comb begin
    locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == BUSY) locked[owner_q[o]] = 1'b1;
    end
  end

  // Build each output's request vector from valid, unlocked inputs whose route targets it.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = in_valid[i] && !locked[i] &&
                    (flit_route(in_flit[i*FLIT_W +: FLIT_W]) == ROUTE_W'(o));
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter_4 u_arb (
      .req       (req[g]),
      .ptr       (ptr_q[g]),
      .gnt_valid (gnt_valid[g]),
      .gnt_idx   (gnt_idx[g])
    );
  end

  // Crossbar: a busy output mirrors its owner's flit and hands its ready back to that owner.
  always_comb begin
    out_valid = '0;
    out_flit  = '0;
    out_tail  = '0;
    in_ready  = '0;
    out_owner = '0;
    out_busy  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_owner[o*ROUTE_W +: ROUTE_W] = owner_q[o];
      if (state_q[o] == BUSY) begin
        out_busy[o]                   = 1'b1;
        out_valid[o]                  = in_valid[owner_q[o]];
        out_tail[o]                   = in_tail[owner_q[o]];
        out_flit[o*FLIT_W +: FLIT_W]  = in_flit[int'(owner_q[o])*FLIT_W +: FLIT_W];
        in_ready[owner_q[o]]          = out_ready[o];
      end
    end
  end

  // Grant on an idle cycle; release after the tail transfers and rotate priority past the owner.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == IDLE) begin
        if (gnt_valid[o]) begin
          state_d[o] = BUSY;
          owner_d[o] = gnt_idx[o];
        end
      end else if (out_valid[o] && out_ready[o] && out_tail[o]) begin
        state_d[o] = IDLE;
        ptr_d[o]   = owner_q[o] + ROUTE_W'(1);
      end
    end
  end

  // State registers; reset discards any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator: grants, round robin, hold, backpressure, lock, reset.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [23:0] in_flit = '0;
  logic [3:0]  in_tail = '0;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [23:0] out_flit;
  logic [3:0]  out_tail;
  logic [3:0]  out_ready = 4'hF;
  logic [7:0]  out_owner;
  logic [3:0]  out_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_tail   (in_tail),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_tail  (out_tail),
    .out_ready (out_ready),
    .out_owner (out_owner),
    .out_busy  (out_busy)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_flit(input int i, input logic [5:0] f);
    in_flit[i*6 +: 6] = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_flit = '0; in_tail = '0; out_ready = 4'hF;
    #13;
    n_checks++; if (out_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want %b", out_busy, 4'b0000); end
    n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want %b", out_valid, 4'b0000); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want %b", in_ready, 4'b0000); end
    n_checks++; if (out_owner !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_owner: got %h want %h", out_owner, 8'h00); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_flit();
    set_flit(0, 6'b01_0110); in_tail = 4'b0001; in_valid = 4'b0001; out_ready = 4'hF;
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_idle_ready: got %b want %b", in_ready, 4'b0000); end
    tick();
    n_checks++; if (out_busy !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_busy: got %b want %b", out_busy, 4'b0010); end
    n_checks++; if (out_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_valid: got %b want %b", out_valid, 4'b0010); end
    n_checks++; if (out_flit[11:6] !== 6'b01_0110) begin n_fail++; $display("[TB] FAIL single_flit: got %b want %b", out_flit[11:6], 6'b01_0110); end
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready: got %b want %b", in_ready, 4'b0001); end
    n_checks++; if (out_tail !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_tail: got %b want %b", out_tail, 4'b0010); end
    tick();
    n_checks++; if (out_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_release: got %b want %b", out_busy, 4'b0000); end
    in_valid = '0; in_tail = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own [4];
    logic [5:0] exp_flit;
    logic [3:0] exp_ready;
    exp_own[0] = 2'd0; exp_own[1] = 2'd2; exp_own[2] = 2'd3; exp_own[3] = 2'd0;
    set_flit(0, 6'b10_0000); set_flit(2, 6'b10_0010); set_flit(3, 6'b10_0011);
    in_tail = 4'b1101; in_valid = 4'b1101;
    for (int n = 0; n < 4; n++) begin
      exp_flit  = {4'b1000, exp_own[n]};
      exp_ready = 4'b0001 << exp_own[n];
      tick();
      n_checks++; if (out_owner[5:4] !== exp_own[n]) begin n_fail++; $display("[TB] FAIL rr_owner[%0d]: got %0d want %0d", n, out_owner[5:4], exp_own[n]); end
      n_checks++; if (out_flit[17:12] !== exp_flit) begin n_fail++; $display("[TB] FAIL rr_flit[%0d]: got %b want %b", n, out_flit[17:12], exp_flit); end
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", n, in_ready, exp_ready); end
      tick();
      n_checks++; if (out_busy[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_gap[%0d]: got %b want %b", n, out_busy[2], 1'b0); end
    end
    in_valid = '0; in_tail = '0;
  endtask

  task automatic test_back_to_back();
    set_flit(1, 6'b00_0001); set_flit(3, 6'b00_1111);
    in_tail = 4'b1000; in_valid = 4'b1010;
    tick();
    n_checks++; if (out_owner[1:0] !== 2'd1) begin n_fail++; $display("[TB] FAIL hold_owner: got %0d want %0d", out_owner[1:0], 2'd1); end
    n_checks++; if (out_flit[5:0] !== 6'b00_0001) begin n_fail++; $display("[TB] FAIL hold_f0: got %b want %b", out_flit[5:0], 6'b00_0001); end
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL hold_ready: got %b want %b", in_ready, 4'b0010); end
    tick();
    set_flit(1, 6'b00_0010);
    #1;
    n_checks++; if (out_flit[5:0] !== 6'b00_0010 || out_tail[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_f1: got %b/%b want %b/0", out_flit[5:0], out_tail[0], 6'b00_0010); end
    tick();
    set_flit(1, 6'b00_0011); in_tail[1] = 1'b1;
    #1;
    n_checks++; if (out_flit[5:0] !== 6'b00_0011 || out_tail[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_f2: got %b/%b want %b/1", out_flit[5:0], out_tail[0], 6'b00_0011); end
    n_checks++; if (out_owner[1:0] !== 2'd1) begin n_fail++; $display("[TB] FAIL hold_owner2: got %0d want %0d", out_owner[1:0], 2'd1); end
    tick();
    n_checks++; if (out_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_bubble: got %b want %b", out_busy[0], 1'b0); end
    in_valid[1] = 1'b0; in_tail[1] = 1'b0;
    tick();
    n_checks++; if (out_busy[0] !== 1'b1 || out_owner[1:0] !== 2'd3) begin n_fail++; $display("[TB] FAIL hold_next: got busy %b owner %0d want busy 1 owner 3", out_busy[0], out_owner[1:0]); end
    n_checks++; if (out_flit[5:0] !== 6'b00_1111) begin n_fail++; $display("[TB] FAIL hold_next_flit: got %b want %b", out_flit[5:0], 6'b00_1111); end
    tick();
    in_valid = '0; in_tail = '0;
  endtask

  task automatic test_backpressure();
    set_flit(2, 6'b11_0101); in_tail = 4'b0100; in_valid = 4'b0100; out_ready = 4'b0111;
    tick();
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (in_ready[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready[%0d]: got %b want %b", n, in_ready[2], 1'b0); end
      n_checks++; if (out_flit[23:18] !== 6'b11_0101 || out_valid[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got %b/%b want %b/1", n, out_flit[23:18], out_valid[3], 6'b11_0101); end
      if (n < 3) tick();
    end
    out_ready = 4'hF;
    #1;
    n_checks++; if (in_ready[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_resume: got %b want %b", in_ready[2], 1'b1); end
    tick();
    n_checks++; if (out_busy[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release: got %b want %b", out_busy[3], 1'b0); end
    in_valid = '0; in_tail = '0;
  endtask

  task automatic test_locked();
    set_flit(0, 6'b01_0000); in_tail = 4'b0000; in_valid = 4'b0001;
    tick();
    n_checks++; if (out_busy !== 4'b0010) begin n_fail++; $display("[TB] FAIL lock_grant: got %b want %b", out_busy, 4'b0010); end
    tick();
    set_flit(0, 6'b11_1010);
    #1;
    n_checks++; if (out_flit[11:6] !== 6'b11_1010) begin n_fail++; $display("[TB] FAIL lock_body: got %b want %b", out_flit[11:6], 6'b11_1010); end
    tick();
    n_checks++; if (out_busy !== 4'b0010 || out_valid[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_out3: got busy %b valid3 %b want busy 0010 valid3 0", out_busy, out_valid[3]); end
    set_flit(0, 6'b11_0001); in_tail = 4'b0001;
    tick();
    n_checks++; if (out_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL lock_release: got %b want %b", out_busy, 4'b0000); end
    in_valid = '0; in_tail = '0;
  endtask

  task automatic test_async_reset();
    set_flit(3, {DIR_S, 4'b1100}); in_tail = 4'b0000; in_valid = 4'b1000;
    tick();
    n_checks++; if (out_busy !== 4'b0100 || out_owner[5:4] !== 2'd3) begin n_fail++; $display("[TB] FAIL areset_pre: got busy %b owner %0d want busy 0100 owner 3", out_busy, out_owner[5:4]); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL areset_busy: got %b want %b", out_busy, 4'b0000); end
    n_checks++; if (out_valid !== 4'b0000 || in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL areset_vr: got valid %b ready %b want 0000/0000", out_valid, in_ready); end
    n_checks++; if (out_owner !== 8'h00) begin n_fail++; $display("[TB] FAIL areset_owner: got %h want %h", out_owner, 8'h00); end
    in_valid = '0;
    #2;
    rst_n = 1'b1;
    set_flit(0, 6'b10_0000); set_flit(1, 6'b10_0001); in_tail = 4'b0011; in_valid = 4'b0011;
    tick();
    n_checks++; if (out_busy !== 4'b0100 || out_owner[5:4] !== 2'd0) begin n_fail++; $display("[TB] FAIL areset_ptr: got busy %b owner %0d want busy 0100 owner 0", out_busy, out_owner[5:4]); end
    n_checks++; if (out_flit[17:12] !== 6'b10_0000) begin n_fail++; $display("[TB] FAIL areset_flit: got %b want %b", out_flit[17:12], 6'b10_0000); end
    tick();
    in_valid = '0; in_tail = '0;
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_locked();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output packet arbiter and crossbar for the mesh router.
- Consumes the 6-bit modified headers (2-bit route over 4-bit dest header) from four input ports, after route computation.
- Grants each of four output ports to one input at a time using round-robin arbitration.
- Holds a grant from head flit to tail flit and forwards flits with a valid/ready handshake.

Parameters:
- NUM_PORTS, 4, number of input and output ports; fixed at 4 because the route field is 2 bits.
- FLIT_W, 6, flit width; bits [FLIT_W-1:FLIT_W-2] are the route field.
- ROUTE_W, 2, route field width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  4  per-input flit valid
- in_flit  input  24  input i flit at [6i+5:6i]
- in_tail  input  4  per-input last-flit-of-packet marker
- in_ready  output  4  per-input flit accepted this cycle when in_valid is also high
- out_valid  output  4  per-output flit valid
- out_flit  output  24  output o flit at [6o+5:6o]
- out_tail  output  4  tail marker forwarded with the flit
- out_ready  input  4  downstream ready per output
- out_owner  output  8  owning input of output o at [2o+1:2o]; meaningful only while out_busy[o]=1
- out_busy  output  4  output o currently granted

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Route decode: output index = route field of the flit (0 north, 1 east, 2 south, 3 west/local as encoded upstream).
- Route bits are sampled only while the target output is IDLE. Flits after the head are steered by ownership, not by their route bits.
- Per-output state, one FSM per output:
  - IDLE: requesters = {i : in_valid[i] && route(i)==o && !locked[i]}. locked[i] = some output BUSY with owner i.
  - IDLE with requesters: round-robin arbitration starting at ptr[o] selects the winner. owner[o] <= winner and the output goes BUSY next cycle.
  - IDLE arbitration costs 1 cycle; no flit transfers in the IDLE cycle.
  - Two outputs in IDLE never select the same input, because each head flit carries one route.
  - BUSY: out_valid[o] = in_valid[owner], out_flit[o] = in_flit[owner], out_tail[o] = in_tail[owner], in_ready[owner] = out_ready[o]. These paths are combinational.
  - Transfer = out_valid[o] && out_ready[o].
  - Transfer with tail: go IDLE and set ptr[o] <= owner+1 (mod 4).
  - Transfer without tail: stay BUSY.
  - Single-flit packet (head with tail=1): granted, transferred, released. This gives a minimum 2 cycles per packet per output.
- Idle outputs: out_valid=0, out_tail=0, out_flit=0. in_ready[i]=0 for every input not owning a BUSY output.
- Simultaneous tail release and new request on the same output: the output goes IDLE and re-arbitrates the next cycle, giving exactly one bubble. The releasing input is lowest priority in that arbitration.
- in_valid dropping while BUSY: out_valid drops and the grant is held. No timeout.
- Reset, including mid-packet: all outputs go IDLE, ptr=0, owner=0, out_busy=0, out_valid=0, in_ready=0. A partial packet is discarded and upstream must resend from a head flit.
- Invariants for the verifier:
  - At most one output BUSY per input.
  - in_ready[i] is never high for an unowned input.
  - Flit order per input is preserved.

Decomposition:
- Shared header/package:
  - NUM_PORTS, FLIT_W, ROUTE_W.
  - Direction constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
  - FSM state encodings IDLE=0, BUSY=1.
- Sub-module rr_arbiter_4: combinational 4-way round-robin.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_valid, gnt_idx[1:0].
  - Instantiated once per output.
- The crossbar muxing and FSMs stay in switch_allocator.

Test Plan:
- Reset, then in0 single flit, route=1 (in_flit[5:0]=6'b01_0110), tail=1, out_ready=4'hF. Expected: out_busy[1]=1 at cycle 1; out_valid[1]=1 with out_flit[11:6]=6'b01_0110 and in_ready[0]=1 at cycle 1; out_busy[1]=0 at cycle 2.
- in0, in2, in3 all head flits to route=2, all tail=1, held valid. Expected grants in order 0,2,3,0, each taking 2 cycles; out_owner[5:4] follows that sequence.
- in1 sends a 3-flit packet to route=0 while in3 sends a head to route=0. Expected: in3 waits until in1's tail transfers, gets the grant one cycle later, and in1's flits arrive contiguously in order.
- out_ready[3]=0 for 4 cycles during a BUSY packet from in2. Expected: in_ready[2]=0 and the flit is held stable on out_flit[23:18]; the transfer completes on the first cycle out_ready[3]=1.
- Locked input: in0 owns output 1 mid-packet and sends a body flit whose route bits say 3. Expected: output 3 stays IDLE and the flit is delivered on output 1.
- Assert rst_n=0 asynchronously mid-packet (between clock edges). Expected: out_valid, in_ready and out_busy go to 0 immediately; after release the next head flit arbitrates with ptr=0.
